// File: rtl/mem_dcache_if.sv
// Request/response bus between the data-cache arbiter (master) and the
// memory-side responder (slave).
interface mem_dcache_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_i_data;
  logic [1:0]        mem_sel;
  logic              mem_cache_enable;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_o_data;
  logic              mem_exception;

  modport master (
    output mem_req, mem_we, mem_addr, mem_i_data, mem_sel, mem_cache_enable,
    input  mem_ack, mem_o_data, mem_exception
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_i_data, mem_sel, mem_cache_enable,
    output mem_ack, mem_o_data, mem_exception
  );
endinterface

// File: rtl/mem_dcache_resp.sv
// Data scratchpad responder: one request at a time, fixed LATENCY, ack with
// read data or a one-cycle exception for out-of-range or write-protected hits.
//
//   state  | meaning
//   IDLE   | waiting for mem_req
//   BUSY   | request latched, counting down latency
//   RESP   | one-cycle ack/exception, write committed on this edge
module mem_dcache_resp #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_dcache_if.slave  bus,
  input  logic         i_wp,
  output logic         o_busy,
  output logic         o_overrun
);
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we, r_err, r_overrun;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_accept, w_err, w_resp_ok, w_wr_en;

  assign w_accept = (r_state == S_IDLE) && bus.mem_req;
  assign w_err    = (bus.mem_addr > LAST_ADDR) | (bus.mem_we & i_wp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_req) begin
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Requests outside IDLE are dropped; the latched request stays intact.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_sel     <= 2'b00;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.mem_we;
        r_err   <= w_err;
        r_idx   <= bus.mem_addr[IDX_W-1:0];
        r_wdata <= bus.mem_i_data;
        r_sel   <= bus.mem_sel;
      end
      if (bus.mem_req && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign w_resp_ok = (r_state == S_RESP) && !r_err;
  assign w_wr_en   = w_resp_ok && r_we && !i_rst;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      if (r_sel[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
      if (r_sel[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
    end
  end

  assign bus.mem_ack       = w_resp_ok;
  assign bus.mem_exception = (r_state == S_RESP) && r_err;
  assign bus.mem_o_data    = (w_resp_ok && !r_we) ? r_mem[r_idx] : '0;
  assign o_busy            = (r_state != S_IDLE);
  assign o_overrun         = r_overrun;
endmodule

// File: doc/mem_dcache_resp.md
Name: mem_dcache_resp

Overview:
- Memory-side responder for the single data-memory request port that the data-cache arbiter drives.
- Accepts one request at a time and services it from an internal word-addressed scratch RAM with a fixed, parameterised latency.
- Returns either an ack (with read data) or an exception.
- Used as the on-chip data scratchpad and as the bench model behind the arbiter.

Parameters:
- ADDR_W, 24, request address width (matches WB_ADDR_W).
- DATA_W, 16, data word width (matches RW); must be 16 (two byte lanes).
- DEPTH, 256, number of DATA_W words implemented; valid addresses are 0..DEPTH-1.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- mem_req  in  1  single-cycle request strobe.
- mem_we  in  1  1 = write, 0 = read; sampled with mem_req.
- mem_addr  in  ADDR_W  word address; sampled with mem_req.
- mem_i_data  in  DATA_W  write data; sampled with mem_req.
- mem_sel  in  2  byte-lane enables for writes (bit0 = [7:0], bit1 = [15:8]); sampled with mem_req.
- mem_cache_enable  in  1  cacheability hint; sampled, no functional effect.
- i_wp  in  1  write-protect; a write sampled while i_wp=1 raises an exception.
- mem_ack  out  1  one-cycle successful-completion strobe.
- mem_o_data  out  DATA_W  read data; valid only while mem_ack=1, otherwise 0.
- mem_exception  out  1  one-cycle failed-completion strobe.
- o_busy  out  1  request in flight (BUSY or RESP state).
- o_overrun  out  1  sticky: a request arrived while not IDLE.

Behaviour:
- Clock and reset: one clock, i_clk; reset is synchronous and active-high on i_rst.
- Reset values: mem_ack=0, mem_exception=0, mem_o_data=0, o_busy=0, o_overrun=0, state=IDLE, latency counter=0. RAM contents are not reset.
- Reset mid-operation: the in-flight request is aborted and produces no ack or exception. A partially timed write is not committed.
- FSM states: IDLE, BUSY, RESP.
- IDLE, mem_req=1:
  - Latch we, addr, i_data, sel.
  - Compute err = (addr >= DEPTH) | (we & i_wp).
  - Load the counter with LATENCY-1.
  - If LATENCY=1, go to RESP; otherwise go to BUSY.
- BUSY: decrement the counter each cycle; when it reaches 1, go to RESP.
- RESP (exactly one cycle), then back to IDLE:
  - err=1: mem_exception=1, mem_ack=0, mem_o_data=0; no RAM write.
  - err=0, read: mem_ack=1, mem_o_data = full word RAM[addr]; mem_sel is ignored for reads.
  - err=0, write: mem_ack=1; RAM[addr] byte lanes with sel=1 are updated on this clock edge; mem_o_data=0. sel=00 still acks and modifies nothing.
- Latency: a request sampled at edge N produces its response during the cycle after edge N+LATENCY-1. With LATENCY=2, a request in cycle 0 is answered in cycle 2.
- mem_ack and mem_exception are never both 1.
- Requests are accepted only in IDLE. A mem_req in BUSY or RESP is dropped: the latched request is unchanged and o_overrun is set until reset. The arbiter protocol never does this (next request comes no earlier than the cycle after ack).
- Back-to-back: a request in the cycle immediately after RESP (state IDLE) is accepted normally.
- Address compare uses the full ADDR_W bits. There is no wrap-around; addresses at or above DEPTH are errors.
- Read-after-write to the same address in consecutive transactions returns the newly written data.
- o_busy=1 in BUSY and RESP states.

Test Plan:
- Write then read, LATENCY=2: write addr 0x10, data 0xBEEF, sel 11; ack occurs 2 cycles after the request. Read addr 0x10 -> mem_ack with mem_o_data=0xBEEF exactly 2 cycles later; mem_o_data=0 in all other cycles.
- Byte lanes: RAM[5]=0x1234; write 0xABCD with sel 01 -> read gives 0x12CD. Write 0xABCD with sel 10 -> read gives 0xABCD. Write with sel 00 -> ack, data unchanged.
- Errors: read addr 256 (DEPTH=256) -> mem_exception for 1 cycle, no ack, o_data=0. Write addr 3 with i_wp=1 -> exception, RAM[3] unchanged on readback.
- Overrun: LATENCY=4; second mem_req 1 cycle after the first -> only one response (for the first request, at +4 cycles); o_overrun=1 and stays 1 until i_rst.
- Reset mid-op: LATENCY=3 write to addr 7 (old value 0x0000), assert i_rst in cycle 1 -> no ack or exception, all outputs 0. Readback of addr 7 returns 0x0000.
- LATENCY=1 back-to-back: 4 reads issued every other cycle -> each acked exactly 1 cycle after its request; o_overrun stays 0.
